// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU MEM stage
// and a debug/loader port. The CPU has default priority; the debug port is
// served after at most MAX_WAIT contended cycles, and a halt mode hands the
// memory to the debug port exclusively.
//
// Optional feature: define DMEM_ARB_STATS_EN to build the saturating 16-bit
// stall/grant statistics counters. Without it both stat ports read 16'h0000
// and no counter flops are built.
module dmem_arbiter #(
  parameter int AW       = 7,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4   // 1..15
) (
  input  logic          clk,
  input  logic          rst_n,
  // CPU MEM stage
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  // debug / loader port
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_halt,
  output logic          halted,
  // data memory
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  // statistics
  output logic [15:0]   stat_stall_cnt,
  output logic [15:0]   stat_dbg_cnt
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;

  logic        w_cpu_req;
  logic        w_grant_dbg;
  logic        w_grant_cpu;
  logic        w_dbg_rd_gnt;

  assign w_cpu_req    = cpu_rd | cpu_wr;
  assign w_dbg_rd_gnt = w_grant_dbg & ~dbg_we;

  // State register: the only FSM flop; halted is decoded straight from it.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave HALTED only once no granted debug read is still
  // waiting for its rvalid, so that read completes while still halted.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:    if (dbg_halt) w_state_nxt = ST_HALTED;
      ST_HALTED: if (!dbg_halt && !w_dbg_rd_gnt) w_state_nxt = ST_RUN;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  // Output logic: grant decision, CPU stall and the memory-side mux.
  always_comb begin
    w_grant_dbg = 1'b0;
    w_grant_cpu = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = cpu_addr;
    mem_wdata   = cpu_wdata;

    if (r_state == ST_HALTED) begin
      w_grant_dbg = dbg_req;
    end else begin
      w_grant_dbg = dbg_req & (~w_cpu_req | (r_wait_cnt == MAX_WAIT_C));
      w_grant_cpu = w_cpu_req & ~w_grant_dbg;
    end

    if (w_grant_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_wr    = dbg_we;
      mem_rd    = ~dbg_we;
    end else if (w_grant_cpu) begin
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
    end
  end

  assign cpu_stall = w_cpu_req & ~w_grant_cpu;
  assign dbg_gnt   = w_grant_dbg;
  assign cpu_rdata = mem_rdata;
  assign halted    = (r_state == ST_HALTED);

  // Starvation counter: counts contended cycles the debug port is denied.
  // Any cycle that is not such a denial (grant, or no debug request) clears
  // it; the grant at MAX_WAIT keeps it from ever passing that value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
    end else if ((r_state == ST_RUN) && dbg_req && w_cpu_req && !w_grant_dbg
                 && (r_wait_cnt != MAX_WAIT_C)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Debug read return: capture the memory word on the grant edge and flag it
  // valid for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= w_dbg_rd_gnt;
      if (w_dbg_rd_gnt) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_stall_cnt;
  logic [15:0] r_stat_dbg_cnt;

  // Saturating statistics: stalled CPU cycles and debug grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_stall_cnt <= 16'h0000;
      r_stat_dbg_cnt   <= 16'h0000;
    end else begin
      if (cpu_stall && (r_stat_stall_cnt != 16'hFFFF)) begin
        r_stat_stall_cnt <= r_stat_stall_cnt + 16'h0001;
      end
      if (w_grant_dbg && (r_stat_dbg_cnt != 16'hFFFF)) begin
        r_stat_dbg_cnt <= r_stat_dbg_cnt + 16'h0001;
      end
    end
  end

  assign stat_stall_cnt = r_stat_stall_cnt;
  assign stat_dbg_cnt   = r_stat_dbg_cnt;
`else
  assign stat_stall_cnt = 16'h0000;
  assign stat_dbg_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a behavioural
// single-port memory (combinational read, write at the clock edge).
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;

`ifdef DMEM_ARB_STATS_EN
  localparam logic [15:0] EXP_STALL = 16'd1;
  localparam logic [15:0] EXP_DBG   = 16'd1;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
  localparam logic [15:0] EXP_DBG   = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_gnt, dbg_rvalid;
  logic          dbg_halt, halted;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   stat_stall_cnt, stat_dbg_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] tb_mem [128];

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_rd         (cpu_rd),
    .cpu_wr         (cpu_wr),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .dbg_req        (dbg_req),
    .dbg_we         (dbg_we),
    .dbg_addr       (dbg_addr),
    .dbg_wdata      (dbg_wdata),
    .dbg_gnt        (dbg_gnt),
    .dbg_rvalid     (dbg_rvalid),
    .dbg_rdata      (dbg_rdata),
    .dbg_halt       (dbg_halt),
    .halted         (halted),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .stat_stall_cnt (stat_stall_cnt),
    .stat_dbg_cnt   (stat_dbg_cnt)
  );

  // Behavioural data memory.
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr] <= mem_wdata;
  end

  // The CPU never issues a read and a write together.
  always @(negedge clk) begin
    if (cpu_rd && cpu_wr) begin
      $display("FAIL cpu_rd_wr_exclusive got both=1 need not both");
      n_errors++;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = '0;
    rst_n = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_halt = 1'b0;

    // ---- reset state
    #3;
    check("rst_halted", halted, 1'b0);
    check("rst_rvalid", dbg_rvalid, 1'b0);
    check("rst_rdata", dbg_rdata, '0);
    check("rst_stall", cpu_stall, 1'b0);
    check("rst_stat_stall", stat_stall_cnt, 16'd0);
    check("rst_stat_dbg", stat_dbg_cnt, 16'd0);
    tick(); tick();
    rst_n = 1'b1;

    // ---- CPU only: write then read back
    tick();
    cpu_wr = 1'b1; cpu_addr = 7'h05; cpu_wdata = 32'hDEADBEEF;
    #1;
    check("cpu_wr_stall", cpu_stall, 1'b0);
    check("cpu_wr_memwr", mem_wr, 1'b1);
    check("cpu_wr_gnt", dbg_gnt, 1'b0);
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    check("cpu_rd_stall", cpu_stall, 1'b0);
    check("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
    check("cpu_rd_memrd", mem_rd, 1'b1);
    check("cpu_rd_gnt", dbg_gnt, 1'b0);

    // ---- starvation bound: grant on the 5th contended cycle
    tick();
    cpu_addr = 7'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h05;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("starve_gnt%0d", i), dbg_gnt, (i == 4));
      check($sformatf("starve_stall%0d", i), cpu_stall, (i == 4));
      check($sformatf("starve_addr%0d", i), mem_addr, (i == 4) ? 7'h05 : 7'h20);
      check($sformatf("starve_wcnt%0d", i), dut.r_wait_cnt, i);
      tick();
    end
    dbg_req = 1'b0;
    #1;
    check("starve_rvalid", dbg_rvalid, 1'b1);
    check("starve_rdata", dbg_rdata, 32'hDEADBEEF);
    check("starve_wcnt_clr", dut.r_wait_cnt, 4'd0);
    check("starve_stall_after", cpu_stall, 1'b0);
    check("stat_stall", stat_stall_cnt, EXP_STALL);
    check("stat_dbg", stat_dbg_cnt, EXP_DBG);
    tick();
    cpu_rd = 1'b0;
    #1;
    check("starve_rvalid_pulse", dbg_rvalid, 1'b0);

    // ---- uncontended debug write, then back-to-back reads
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h10; dbg_wdata = 32'h12345678;
    #1;
    check("udbg_wr_gnt", dbg_gnt, 1'b1);
    check("udbg_wr_memwr", mem_wr, 1'b1);
    check("udbg_wr_addr", mem_addr, 7'h10);
    check("udbg_wr_wdata", mem_wdata, 32'h12345678);
    tick();
    dbg_we = 1'b0;
    #1;
    check("udbg_rd_gnt", dbg_gnt, 1'b1);
    check("udbg_rd_memrd", mem_rd, 1'b1);
    check("udbg_rd_novalid", dbg_rvalid, 1'b0);
    tick();
    dbg_addr = 7'h05;
    #1;
    check("udbg_rd1_valid", dbg_rvalid, 1'b1);
    check("udbg_rd1_data", dbg_rdata, 32'h12345678);
    tick();
    dbg_req = 1'b0;
    #1;
    check("udbg_rd2_valid", dbg_rvalid, 1'b1);
    check("udbg_rd2_data", dbg_rdata, 32'hDEADBEEF);
    tick();
    check("udbg_rd_end", dbg_rvalid, 1'b0);

    // ---- halt mode
    dbg_halt = 1'b1;
    #1;
    check("halt_not_yet", halted, 1'b0);
    tick();
    check("halt_entered", halted, 1'b1);
    cpu_wr = 1'b1; cpu_addr = 7'h01; cpu_wdata = 32'hA5A5A5A5;
    #1;
    check("halt_cpu_stall", cpu_stall, 1'b1);
    check("halt_cpu_nowr", mem_wr, 1'b0);
    tick();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h11; dbg_wdata = 32'h00000055;
    #1;
    check("halt_dwr_gnt", dbg_gnt, 1'b1);
    check("halt_dwr_memwr", mem_wr, 1'b1);
    check("halt_dwr_addr", mem_addr, 7'h11);
    check("halt_dwr_stall", cpu_stall, 1'b1);
    tick();
    dbg_we = 1'b0; dbg_halt = 1'b0;
    #1;
    check("halt_drd_gnt", dbg_gnt, 1'b1);
    check("halt_drd_memrd", mem_rd, 1'b1);
    check("halt_drd_halted", halted, 1'b1);
    check("halt_drd_stall", cpu_stall, 1'b1);
    tick();
    dbg_req = 1'b0;
    #1;
    check("halt_hold_extra", halted, 1'b1);
    check("halt_rvalid", dbg_rvalid, 1'b1);
    check("halt_rdata", dbg_rdata, 32'h00000055);
    check("halt_hold_stall", cpu_stall, 1'b1);
    check("halt_hold_nowr", mem_wr, 1'b0);
    tick();
    check("halt_exit", halted, 1'b0);
    check("halt_exit_stall", cpu_stall, 1'b0);
    check("halt_exit_memwr", mem_wr, 1'b1);
    check("halt_exit_addr", mem_addr, 7'h01);
    tick();
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    #1;
    check("halt_cpu_rdback", cpu_rdata, 32'hA5A5A5A5);
    check("halt_cpu_rd_stall", cpu_stall, 1'b0);

    // ---- reset in the middle of a debug read
    tick();
    cpu_addr = 7'h20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h10;
    tick(); tick();
    check("mrst_wcnt_pre", dut.r_wait_cnt, 4'd2);
    cpu_rd = 1'b0; dbg_halt = 1'b1;
    #1;
    check("mrst_gnt", dbg_gnt, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_wcnt_async", dut.r_wait_cnt, 4'd0);
    dbg_req = 1'b0; dbg_halt = 1'b0;
    tick();
    check("mrst_rvalid", dbg_rvalid, 1'b0);
    check("mrst_rdata", dbg_rdata, '0);
    check("mrst_halted", halted, 1'b0);
    check("mrst_wcnt", dut.r_wait_cnt, 4'd0);
    #2;
    rst_n = 1'b1;
    tick();
    cpu_wr = 1'b1; cpu_addr = 7'h02; cpu_wdata = 32'h0BADF00D;
    #1;
    check("mrst_cpu_stall", cpu_stall, 1'b0);
    check("mrst_cpu_memwr", mem_wr, 1'b1);
    check("mrst_cpu_gnt", dbg_gnt, 1'b0);
    tick();
    cpu_wr = 1'b0;
    check("mrst_cpu_commit", tb_mem[2], 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
